// File: rtl/digi_ota_pkg.sv
// rtl/digi_ota_pkg.sv - shared types and helpers for the digital OTA array
//
// Purpose: state and direction encodings plus the integrator mid-scale helper.
// Ports:   none (package).
package digi_ota_pkg;

  typedef enum logic {
    HIZ   = 1'b0,
    DRIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    UP = 2'b01,
    DN = 2'b10
  } dir_t;

  // Integrator reset value: half of full scale.
  function automatic int mid(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// rtl/digi_ota_chan.sv - one OTA channel: synchroniser, FSM, integrator, PDM modulator
//
// Purpose: integrates the synchronised vip/vin difference in a saturating
//          counter and turns it into a 1-bit sigma-delta drive with enable.
// Option:  DIGI_OTA_HYST_EN - step only on the second and later consecutive
//          identical non-EQ directions.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_ena           global enable (low: high-Z, counter held)
//   i_vip, i_vin    asynchronous comparator inputs
//   o_pdm, o_oe     registered PDM bit and pad enable
//   o_count         integrator value
//   o_sat_hi/lo     integrator at full scale / zero
module digi_ota_chan
  import digi_ota_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STEP     = 1,
  parameter int IDLE_CYC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_vip,
  input  logic             i_vin,
  output logic             o_pdm,
  output logic             o_oe,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat_hi,
  output logic             o_sat_lo
);

  localparam int               CW1       = CNT_W + 1;
  localparam logic [CNT_W-1:0] MID       = CNT_W'(mid(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   STEP_X    = CW1'(STEP);
  localparam int               IDLE_W    = (IDLE_CYC > 1) ? $clog2(IDLE_CYC + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);

  logic              r_vp_s1, r_vp_s2, r_vn_s1, r_vn_s2;
  state_t            r_state, w_state_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [CNT_W-1:0]  r_acc;
  logic              r_pdm;
  dir_t              w_dir;
  logic              w_step_ok;
  logic              w_step;
  logic [CNT_W:0]    w_up, w_dn, w_sum;

  always_comb begin
    case ({r_vp_s2, r_vn_s2})
      2'b10:   w_dir = UP;
      2'b01:   w_dir = DN;
      default: w_dir = EQ;
    endcase
  end

`ifdef DIGI_OTA_HYST_EN
  // Last cycle's direction; a step needs the same non-EQ direction twice in
  // a row, so alternating UP/DN never moves the integrator.
  dir_t r_hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_hist <= EQ;
    else       r_hist <= i_ena ? w_dir : EQ;
  end

  assign w_step_ok = (w_dir == r_hist);
`else
  assign w_step_ok = 1'b1;
`endif

  // Any non-EQ cycle with ena either keeps DRIVE or enters it, so the step
  // condition does not need to look at the state.
  assign w_step = i_ena && (w_dir != EQ) && w_step_ok;

  // One guard bit catches both overflow and borrow for the clamp.
  assign w_up  = {1'b0, r_count} + STEP_X;
  assign w_dn  = {1'b0, r_count} - STEP_X;
  assign w_sum = {1'b0, r_acc} + {1'b0, r_count};

  always_comb begin
    w_count_nxt = r_count;
    if (w_step) begin
      case (w_dir)
        UP:      w_count_nxt = w_up[CNT_W] ? CNT_MAX : w_up[CNT_W-1:0];
        DN:      w_count_nxt = w_dn[CNT_W] ? '0 : w_dn[CNT_W-1:0];
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    if (!i_ena) begin
      w_state_nxt = HIZ;
      w_idle_nxt  = '0;
    end else begin
      case (r_state)
        HIZ: begin
          if (w_dir != EQ) begin
            w_state_nxt = DRIVE;
            w_idle_nxt  = '0;
          end
        end
        DRIVE: begin
          if (w_dir != EQ) begin
            w_idle_nxt = '0;
          end else if (IDLE_CYC > 0) begin
            if (r_idle == IDLE_LAST) begin
              w_state_nxt = HIZ;
              w_idle_nxt  = '0;
            end else begin
              w_idle_nxt = r_idle + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = HIZ;
          w_idle_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vp_s1 <= 1'b0;
      r_vp_s2 <= 1'b0;
      r_vn_s1 <= 1'b0;
      r_vn_s2 <= 1'b0;
      r_state <= HIZ;
      r_idle  <= '0;
      r_count <= MID;
      r_acc   <= '0;
      r_pdm   <= 1'b0;
    end else begin
      r_vp_s1 <= i_vip;
      r_vp_s2 <= r_vp_s1;
      r_vn_s1 <= i_vin;
      r_vn_s2 <= r_vn_s1;
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_count <= w_count_nxt;
      // Modulator runs every cycle; the pad only sees it while o_oe is high.
      r_acc   <= w_sum[CNT_W-1:0];
      r_pdm   <= w_sum[CNT_W];
    end
  end

  assign o_pdm    = r_pdm;
  assign o_oe     = (r_state == DRIVE);
  assign o_count  = r_count;
  assign o_sat_hi = (r_count == CNT_MAX);
  assign o_sat_lo = (r_count == '0);

endmodule

// File: rtl/digi_ota_array.sv
// rtl/digi_ota_array.sv - array of independent clocked digital OTA channels
//
// Purpose: CHANNELS copies of digi_ota_chan with their outputs packed onto buses.
// Option:  DIGI_OTA_HYST_EN (see digi_ota_chan) selects integrator hysteresis.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               global enable
//   vip, vin          per-channel asynchronous comparator inputs
//   out_pdm, out_oe   per-channel PDM bit and pad enable
//   count             integrators, channel k at [k*CNT_W +: CNT_W]
//   sat_hi, sat_lo    per-channel saturation flags
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int STEP     = 1,
  parameter int IDLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [CHANNELS-1:0]       vip,
  input  logic [CHANNELS-1:0]       vin,
  output logic [CHANNELS-1:0]       out_pdm,
  output logic [CHANNELS-1:0]       out_oe,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       sat_hi,
  output logic [CHANNELS-1:0]       sat_lo
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    digi_ota_chan #(
      .CNT_W    (CNT_W),
      .STEP     (STEP),
      .IDLE_CYC (IDLE_CYC)
    ) u_chan (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_ena    (ena),
      .i_vip    (vip[k]),
      .i_vin    (vin[k]),
      .o_pdm    (out_pdm[k]),
      .o_oe     (out_oe[k]),
      .o_count  (count[k*CNT_W +: CNT_W]),
      .o_sat_hi (sat_hi[k]),
      .o_sat_lo (sat_lo[k])
    );
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// tb/tb_digi_ota_array.sv - self-checking bench for digi_ota_array
module tb_digi_ota_array;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int STEP = 1;
  localparam int IDLE = 4;
  localparam int FULL = 1 << W;
`ifdef DIGI_OTA_HYST_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic            clk = 1'b0;
  logic            r_rst, r_ena;
  logic [CH-1:0]   r_vip, r_vin;
  logic [CH-1:0]   out_pdm, out_oe, sat_hi, sat_lo;
  logic [CH*W-1:0] count;

  digi_ota_array #(.CHANNELS(CH), .CNT_W(W), .STEP(STEP), .IDLE_CYC(IDLE)) dut (
    .clk(clk), .rst(r_rst), .ena(r_ena), .vip(r_vip), .vin(r_vin),
    .out_pdm(out_pdm), .out_oe(out_oe), .count(count),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   oe;
    logic [CH-1:0]   pdm;
    logic [CH-1:0]   shi;
    logic [CH-1:0]   slo;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [CH-1:0] vp;
    logic [CH-1:0] vn;
    logic          en;
    int            cyc;
    int            c0;
    int            c1;
    logic [CH-1:0] oe;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model, one entry per channel.
  int m_s1p[CH], m_s1n[CH], m_s2p[CH], m_s2n[CH];
  int m_cnt[CH], m_drv[CH], m_idle[CH], m_acc[CH], m_pdm[CH], m_hist[CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    for (int c = 0; c < CH; c++) begin
      m_s1p[c] = 0; m_s1n[c] = 0; m_s2p[c] = 0; m_s2n[c] = 0;
      m_cnt[c] = FULL / 2; m_drv[c] = 0; m_idle[c] = 0;
      m_acc[c] = 0; m_pdm[c] = 0; m_hist[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      int d;
      int nc;
      int sum;
      d = (m_s2p[c] == 1 && m_s2n[c] == 0) ? 1 : (m_s2p[c] == 0 && m_s2n[c] == 1) ? -1 : 0;
      sum = m_acc[c] + m_cnt[c];
      m_pdm[c] = (sum >= FULL) ? 1 : 0;
      m_acc[c] = sum % FULL;
      if (r_ena && d != 0 && (H == 0 || d == m_hist[c])) begin
        nc = m_cnt[c] + d * STEP;
        if (nc > FULL - 1) nc = FULL - 1;
        if (nc < 0) nc = 0;
        m_cnt[c] = nc;
      end
      if (!r_ena) begin
        m_drv[c] = 0; m_idle[c] = 0;
      end else if (d != 0) begin
        m_drv[c] = 1; m_idle[c] = 0;
      end else if (m_drv[c] == 1) begin
        m_idle[c]++;
        if (IDLE > 0 && m_idle[c] >= IDLE) begin
          m_drv[c] = 0; m_idle[c] = 0;
        end
      end
      m_hist[c] = r_ena ? d : 0;
      m_s2p[c] = m_s1p[c]; m_s1p[c] = int'(r_vip[c]);
      m_s2n[c] = m_s1n[c]; m_s1n[c] = int'(r_vin[c]);
    end
  endfunction

  // Predict the post-edge outputs, queue them, then compare after the edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    model_step();
    for (int c = 0; c < CH; c++) begin
      e.cnt[c*W +: W] = W'(m_cnt[c]);
      e.oe[c]  = (m_drv[c] == 1);
      e.pdm[c] = (m_pdm[c] == 1);
      e.shi[c] = (m_cnt[c] == FULL - 1);
      e.slo[c] = (m_cnt[c] == 0);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sbq.pop_front();
      chk("sb_count",  32'(count),   32'(g.cnt));
      chk("sb_oe",     32'(out_oe),  32'(g.oe));
      chk("sb_pdm",    32'(out_pdm), 32'(g.pdm));
      chk("sb_sat_hi", 32'(sat_hi),  32'(g.shi));
      chk("sb_sat_lo", 32'(sat_lo),  32'(g.slo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones0;
    int ones1;
    int guard;

    // ch0 = bit 0, ch1 = bit 1. UP = (vp=1,vn=0), DN = (vp=0,vn=1).
    vecs.push_back('{2'b01, 2'b10, 1'b1,   2, 128,     128,     2'b00}); // step latency
    vecs.push_back('{2'b01, 2'b10, 1'b1,   1, 129 - H, 127 + H, 2'b11});
    vecs.push_back('{2'b01, 2'b10, 1'b1,   7, 136 - H, 120 + H, 2'b11});
    vecs.push_back('{2'b01, 2'b10, 1'b1, 200, 255,     0,       2'b11}); // saturate
    vecs.push_back('{2'b10, 2'b01, 1'b1, 300, 0,       255,     2'b11}); // reverse
    vecs.push_back('{2'b01, 2'b00, 1'b1, 192 + H, 190, 255,     2'b01}); // toward 192
    vecs.push_back('{2'b01, 2'b01, 1'b1,   5, 192,     255,     2'b01}); // 3 EQ seen
    vecs.push_back('{2'b01, 2'b01, 1'b1,   1, 192,     255,     2'b00}); // 4th EQ: HIZ
    vecs.push_back('{2'b01, 2'b00, 1'b1,   1, 192,     255,     2'b00});
    vecs.push_back('{2'b01, 2'b01, 1'b1,   3, 193 - H, 255,     2'b01});
    vecs.push_back('{2'b01, 2'b00, 1'b1,   1, 193 - H, 255,     2'b01});
    vecs.push_back('{2'b01, 2'b01, 1'b1,   5, 194 - 2*H, 255,   2'b01}); // idle restarted
    vecs.push_back('{2'b01, 2'b01, 1'b1,   1, 194 - 2*H, 255,   2'b00});
    vecs.push_back('{2'b01, 2'b00, 1'b1,   5, 197 - 3*H, 255,   2'b01});
    vecs.push_back('{2'b01, 2'b00, 1'b0,   1, 197 - 3*H, 255,   2'b00}); // ena low
    vecs.push_back('{2'b01, 2'b00, 1'b0,   5, 197 - 3*H, 255,   2'b00});
    vecs.push_back('{2'b01, 2'b00, 1'b1,   1, 198 - 4*H, 255,   2'b01});

    r_rst = 1'b1; r_ena = 1'b1; r_vip = '0; r_vin = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",  32'(count),   32'h8080);
    chk("rst_oe",     32'(out_oe),  32'd0);
    chk("rst_pdm",    32'(out_pdm), 32'd0);
    chk("rst_sat",    32'({sat_hi, sat_lo}), 32'd0);
    r_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      r_vip = vecs[i].vp; r_vin = vecs[i].vn; r_ena = vecs[i].en;
      repeat (vecs[i].cyc) tick();
      chk($sformatf("vec%0d_cnt0", i), 32'(count[0 +: W]), 32'(vecs[i].c0));
      chk($sformatf("vec%0d_cnt1", i), 32'(count[W +: W]), 32'(vecs[i].c1));
      chk($sformatf("vec%0d_oe", i),   32'(out_oe),         32'(vecs[i].oe));
      if (i == 3) chk("sat_hi0", 32'(sat_hi[0]), 32'd1);
      if (i == 4) chk("sat_lo0", 32'(sat_lo[0]), 32'd1);
      // After the idle release ch0 sits at 192, ch1 at 255: measure duty.
      if (i == 7) begin
        ones0 = 0; ones1 = 0;
        for (int k = 0; k < FULL; k++) begin
          tick();
          ones0 += int'(out_pdm[0]);
          ones1 += int'(out_pdm[1]);
        end
        chk("duty_192", 32'(ones0), 32'd192);
        chk("duty_255", 32'(ones1), 32'd255);
      end
    end

    // Walk ch0 down to 150 in DRIVE, then pulse reset between edges.
    r_vip = 2'b00; r_vin = 2'b01; r_ena = 1'b1;
    guard = 0;
    while (m_cnt[0] != 150 && guard < 150) begin
      tick();
      guard++;
    end
    chk("pre_rst_cnt0", 32'(count[0 +: W]), 32'd150);
    chk("pre_rst_oe0",  32'(out_oe[0]),     32'd1);
    #3;
    r_rst = 1'b1; r_vip = '0; r_vin = '0;
    #1;
    chk("async_count", 32'(count),   32'h8080);
    chk("async_oe",    32'(out_oe),  32'd0);
    chk("async_pdm",   32'(out_pdm), 32'd0);
    #1;
    r_rst = 1'b0;
    reset_model();

    // At mid-scale the modulator output alternates 0,1,0,1...
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("pdm_alt%0d", k), 32'(out_pdm[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Alternating UP/DN on ch0.
    for (int k = 1; k <= 50; k++) begin
      r_vip = (k % 2 == 1) ? 2'b01 : 2'b00;
      r_vin = (k % 2 == 1) ? 2'b00 : 2'b01;
      tick();
      if (k == 49) chk("alt49_cnt0", 32'(count[0 +: W]), 32'(129 - H));
    end
    chk("alt50_cnt0", 32'(count[0 +: W]), 32'd128);

    r_vip = 2'b01; r_vin = 2'b00;
    repeat (5) tick();
    chk("resume_cnt0", 32'(count[0 +: W]), 32'(131 - H));
    chk("resume_cnt1", 32'(count[W +: W]), 32'd128);
    chk("resume_oe",   32'(out_oe),        32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
